// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned PC_STEP = 4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } fetch_out_t;

endpackage

// File: rtl/fetch_out_reg.sv
// Valid/ready output register: holds its contents while stalled, and can be
// flushed synchronously (flush wins over load).
module fetch_out_reg
  import fetch_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            load,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_pc_plus4,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc_plus4
);

  logic       valid_q, valid_d;
  fetch_out_t data_q, data_d;

  // Next-state: flush clears valid, load captures, a transfer without reload empties.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d        = 1'b1;
      data_d.instr    = in_instr;
      data_d.pc       = in_pc;
      data_d.pc_plus4 = in_pc_plus4;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Register with synchronous reset to an empty, zeroed state.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_instr    = data_q.instr;
  assign out_pc       = data_q.pc;
  assign out_pc_plus4 = data_q.pc_plus4;

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, drives the combinational ROM address,
// captures the returned word into a valid/ready output register, handles
// redirects and halts on misaligned (or, with FETCH_BOUND_CHECK_EN defined,
// out-of-range) fetch targets.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned ROM_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] instr_addr,
  input  logic [31:0] instr_data,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic        fault,
  output logic [31:0] fault_pc
);

  localparam logic [XLEN-1:0] PC_LIMIT = XLEN'(ROM_DEPTH * 4);
  localparam logic [XLEN-1:0] PC_INC   = XLEN'(PC_STEP);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            fault_q, fault_d;
  logic [XLEN-1:0] fault_pc_q, fault_pc_d;

  logic            accept;
  logic            load;
  logic            flush;
  logic [XLEN-1:0] pc_plus4;
  logic            redirect_oob;
  logic            pc_oob;
  fetch_out_t      cap;

`ifdef FETCH_BOUND_CHECK_EN
  // Range check against the ROM size, applied to both redirect targets and the current PC.
  always_comb begin
    redirect_oob = (redirect_pc >= PC_LIMIT);
    pc_oob       = (pc_q >= PC_LIMIT);
  end
`else
  logic unused_pc_limit;
  assign unused_pc_limit = ^PC_LIMIT;

  // No range check: out-of-range PCs are fetched as-is.
  always_comb begin
    redirect_oob = 1'b0;
    pc_oob       = 1'b0;
  end
`endif

  assign pc_plus4 = pc_q + PC_INC;
  assign accept   = !out_valid || out_ready;

  // Next-state, PC and fault logic; redirect takes priority over capture.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    load       = 1'b0;
    flush      = 1'b0;
    cap.instr    = instr_data;
    cap.pc       = pc_q;
    cap.pc_plus4 = pc_plus4;
    unique case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (redirect_en) begin
          flush = 1'b1;
          if ((redirect_pc[1:0] != 2'b00) || redirect_oob) begin
            state_d    = FAULT;
            fault_d    = 1'b1;
            fault_pc_d = redirect_pc;
          end else begin
            pc_d = redirect_pc;
          end
        end else if (accept) begin
          if (pc_oob) begin
            flush      = 1'b1;
            state_d    = FAULT;
            fault_d    = 1'b1;
            fault_pc_d = pc_q;
          end else begin
            load = 1'b1;
            pc_d = pc_plus4;
          end
        end
      end
      FAULT: begin
        flush = 1'b1;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // State, PC and sticky fault registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  fetch_out_reg u_out_reg (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .load         (load),
    .in_instr     (cap.instr),
    .in_pc        (cap.pc),
    .in_pc_plus4  (cap.pc_plus4),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_instr    (out_instr),
    .out_pc       (out_pc),
    .out_pc_plus4 (out_pc_plus4)
  );

  assign instr_addr = pc_q;
  assign fault      = fault_q;
  assign fault_pc   = fault_pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed, table-driven bench for instr_fetch with a combinational ROM model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_addr;
  logic [31:0] instr_data;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic        fault;
  logic [31:0] fault_pc;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic        rst;
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eaddr;
    logic        ef;
    logic [31:0] efpc;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  assign instr_data = rom_word(instr_addr);

  instr_fetch #(.RESET_PC(32'h0000_0000), .ROM_DEPTH(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .instr_addr   (instr_addr),
    .instr_data   (instr_data),
    .redirect_en  (redirect_en),
    .redirect_pc  (redirect_pc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instr    (out_instr),
    .out_pc       (out_pc),
    .out_pc_plus4 (out_pc_plus4),
    .fault        (fault),
    .fault_pc     (fault_pc)
  );

  function automatic vec_t mk(input logic rst, input logic redir, input logic [31:0] rpc,
                              input logic rdy, input logic ev, input logic [31:0] epc,
                              input logic [31:0] eaddr, input logic ef, input logic [31:0] efpc);
    vec_t v;
    v.rst = rst; v.redir = redir; v.rpc = rpc; v.rdy = rdy; v.ev = ev;
    v.epc = epc; v.eaddr = eaddr; v.ef = ef; v.efpc = efpc;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clk);
    reset       = v.rst;
    redirect_en = v.redir;
    redirect_pc = v.rpc;
    out_ready   = v.rdy;
    @(posedge clk);
    #1;
    check("out_valid", idx, {31'b0, out_valid}, {31'b0, v.ev});
    check("instr_addr", idx, instr_addr, v.eaddr);
    check("fault", idx, {31'b0, fault}, {31'b0, v.ef});
    check("fault_pc", idx, fault_pc, v.efpc);
    if (v.ev) begin
      check("out_pc", idx, out_pc, v.epc);
      check("out_pc_plus4", idx, out_pc_plus4, v.epc + 32'd4);
      check("out_instr", idx, out_instr, rom_word(v.epc));
    end
  endtask

  initial begin
    reset = 1'b1; redirect_en = 1'b0; redirect_pc = '0; out_ready = 1'b1;

    //          rst   rd    rpc           rdy   ev    epc           eaddr         f     fpc
    vecs.push_back(mk(1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        32'h0,        1'b0, 32'h0));
    vecs.push_back(mk(1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        32'h0,        1'b0, 32'h0));
    // BOOT, then steady fetch 0,4,8
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        32'h0,        1'b0, 32'h0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'd0,        32'd4,        1'b0, 32'h0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'd4,        32'd8,        1'b0, 32'h0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'd8,        32'd12,       1'b0, 32'h0));
    // three-cycle stall at out_pc = 8
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'd8,        32'd12,       1'b0, 32'h0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'd8,        32'd12,       1'b0, 32'h0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'd8,        32'd12,       1'b0, 32'h0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'd12,       32'd16,       1'b0, 32'h0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'd16,       32'd20,       1'b0, 32'h0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'd20,       32'd24,       1'b0, 32'h0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'd24,       32'd28,       1'b0, 32'h0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'd28,       32'd32,       1'b0, 32'h0));
    // redirect to 44 while out_pc = 28 valid
    vecs.push_back(mk(1'b0, 1'b1, 32'd44,       1'b1, 1'b0, 32'h0,        32'd44,       1'b0, 32'h0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'd44,       32'd48,       1'b0, 32'h0));
    // redirect during a stall still flushes
    vecs.push_back(mk(1'b0, 1'b1, 32'd44,       1'b0, 1'b0, 32'h0,        32'd44,       1'b0, 32'h0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'd44,       32'd48,       1'b0, 32'h0));
    // misaligned redirect -> FAULT; later redirects ignored
    vecs.push_back(mk(1'b0, 1'b1, 32'h12,       1'b0, 1'b0, 32'h0,        32'd48,       1'b1, 32'h12));
    vecs.push_back(mk(1'b0, 1'b1, 32'd8,        1'b1, 1'b0, 32'h0,        32'd48,       1'b1, 32'h12));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'd48,       1'b1, 32'h12));
    // reset during a stall with fault set
    vecs.push_back(mk(1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 32'h0));

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    check("rst_out_instr", 100, out_instr, 32'h0);
    check("rst_out_pc", 100, out_pc, 32'h0);
    check("rst_out_pc_plus4", 100, out_pc_plus4, 32'h0);

    // redirect in BOOT ignored, then wrap-around at the top of the address space
    vecs.delete();
    vecs.push_back(mk(1'b0, 1'b1, 32'h40,       1'b1, 1'b0, 32'h0,        32'h0,        1'b0, 32'h0));
`ifdef FETCH_BOUND_CHECK_EN
    vecs.push_back(mk(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0,       32'h0,        1'b1, 32'hFFFF_FFFC));
`else
    vecs.push_back(mk(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0,       32'hFFFF_FFFC, 1'b0, 32'h0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0,       1'b0, 32'h0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0,        32'd4,        1'b0, 32'h0));
`endif
    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], 200 + i);

`ifdef FETCH_BOUND_CHECK_EN
    // sequential fetch up to the ROM end: pc = 64 faults without capture
    vecs.delete();
    vecs.push_back(mk(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0));
    for (int k = 0; k < 16; k++)
      vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'(k * 4), 32'(k * 4 + 4), 1'b0, 32'h0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'd64, 1'b1, 32'd64));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'd64, 1'b1, 32'd64));
    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], 300 + i);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
